mult_hilo_unit: RTL and testbench
=================================

MULT_HILO_UNIT -- requirements
Module: mult_hilo_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; HI/LO are each WIDTH bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  execute-stage MULTU issue request.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand (rs value after forwarding).
REQ-006 SHALL have port: b  input  WIDTH  multiplier (rt value after forwarding).
REQ-007 SHALL have port: flush  input  1  pipeline flush; aborts an in-flight multiply.
REQ-008 SHALL have port: hilo_rd  input  1  MFHI/MFLO in execute requesting HI/LO.
REQ-009 SHALL have port: hilo_sel  input  1  read select: 1 = HI, 0 = LO.
REQ-010 SHALL have port: we_hi / we_lo  input  1 each  MTHI/MTLO write enables.
REQ-011 SHALL have port: wd  input  WIDTH  MTHI/MTLO write data.
REQ-012 SHALL have port: rd_data  output  WIDTH  selected HI or LO, combinational from registers.
REQ-013 SHALL have port: busy  output  1  multiply in progress.
REQ-014 SHALL have port: stall  output  1  hold request to fetch/decode/execute pipeline registers.
REQ-015 SHALL have port: done  output  1  one-cycle pulse when HI/LO are updated by a multiply.
REQ-016 SHALL have port: hi, lo  output  WIDTH each  architectural HI/LO register contents.

Function
REQ-017 SHALL implement FSM states IDLE and RUN; busy = (state == RUN).
REQ-018 In IDLE, start=1 and flush=0 at an edge SHALL latch a and b, clear the 2*WIDTH accumulator, clear the iteration counter, and enter RUN.
REQ-019 In RUN, each edge SHALL perform one radix-2 shift-add step: if multiplier LSB = 1, add the multiplicand into the accumulator; shift the multiplicand left and the multiplier right; increment the counter.
REQ-020 Arithmetic SHALL be unsigned with a 2*WIDTH-bit accumulator and no truncation.
REQ-021 On the edge completing iteration WIDTH-1, the unit SHALL write {hi, lo} = a*b, return to IDLE, and assert done for exactly the following cycle.
REQ-022 Latency: with start sampled at edge k, busy SHALL be 1 for cycles k+1..k+WIDTH, and hi/lo and done SHALL be valid in cycle k+WIDTH+1.
REQ-023 start while busy SHALL NOT restart or relatch operands.
REQ-024 stall SHALL be busy AND (start OR hilo_rd OR we_hi OR we_lo), combinational, so that dependent instructions hold in execute until the multiply completes.
REQ-025 we_hi / we_lo SHALL write wd into HI / LO at the edge only when not busy.
REQ-026 When not busy, start together with we_hi or we_lo SHALL give start priority, and the write SHALL be ignored.
REQ-027 rd_data SHALL equal hi when hilo_sel = 1, else lo, and SHALL reflect a same-edge MTHI/MTLO write in the next cycle.
REQ-028 flush = 1 in RUN SHALL return to IDLE at the edge with hi/lo unchanged and no done pulse.
REQ-029 flush = 1 in IDLE SHALL suppress start and we_hi/we_lo at that edge.
REQ-030 Operands of 0 SHALL still take the full WIDTH cycles, with no early termination, so latency is constant.

Reset
REQ-031 rst = 0 SHALL immediately force state IDLE, hi = 0, lo = 0, accumulator = 0, counter = 0, busy = 0, stall = 0, done = 0, independent of clk.
REQ-032 Reset asserted during RUN SHALL abort the multiply with no done pulse; after release the unit SHALL accept start on the first edge.

Verification
REQ-033 Bench SHALL cover: start with a = 2, b = 4 -> busy for 32 cycles, done in cycle 33, hi = 0, lo = 8, then hilo_sel = 0 gives rd_data = 8.
REQ-034 Bench SHALL cover: a = b = 32'hFFFFFFFF -> hi = 32'hFFFFFFFE, lo = 32'h00000001 after 33 cycles.
REQ-035 Bench SHALL cover: hilo_rd = 1 asserted 5 cycles after start -> stall = 1 until busy falls, and rd_data then shows the new product.
REQ-036 Bench SHALL cover: flush at cycle 10 of RUN with prior hi/lo = 0x1234/0x5678 -> IDLE next cycle, no done, hi/lo unchanged.
REQ-037 Bench SHALL cover: rst low mid-RUN -> all outputs 0 immediately; release, then start 3*5 -> lo = 15 at 33 cycles.
REQ-038 Bench SHALL cover: we_hi = 1, wd = 32'hDEADBEEF while idle -> hi = 32'hDEADBEEF next cycle; the same write while busy -> stall = 1 and hi unchanged.

Source files
------------

// File: rtl/mult_hilo_unit.sv
// MULTU shift-add unit with HI/LO: result and done arrive WIDTH+1 cycles after start, with a constant latency.
// No backpressure: while busy, stall holds any HI/LO consumer or second start, and writes to HI/LO are dropped.
module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hilo_rd,
    input  logic             hilo_sel,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [0:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] step_sum;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

        if (state_q == S_IDLE) begin
            if (!flush) begin
                // start takes priority over a same-edge MTHI/MTLO
                if (start) begin
                    state_d  = S_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    if (we_hi) hi_d = wd;
                    if (we_lo) lo_d = wd;
                end
            end
        end else begin
            if (flush) begin
                state_d = S_IDLE;
            end else begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d      = S_IDLE;
                    {hi_d, lo_d} = step_sum;
                    done_d       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign stall   = busy & (start | hilo_rd | we_hi | we_lo);
    assign rd_data = hilo_sel ? hi_q : lo_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: directed corner cases plus random operands against a 64-bit arithmetic model of HI/LO.
module tb_mult_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        flush;
    logic        hilo_rd;
    logic        hilo_sel;
    logic        we_hi, we_lo;
    logic [31:0] wd;
    logic [31:0] rd_data;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    mult_hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .flush(flush),
        .hilo_rd(hilo_rd), .hilo_sel(hilo_sel), .we_hi(we_hi), .we_lo(we_lo),
        .wd(wd), .rd_data(rd_data), .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue start at a negedge; returns at the negedge of the first RUN cycle.
    task automatic start_op(input logic [31:0] op_a, input logic [31:0] op_b);
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_mult(input string tag, input logic [31:0] op_a, input logic [31:0] op_b);
        logic [63:0] prod;
        int n;
        prod = {32'd0, op_a} * {32'd0, op_b};
        start_op(op_a, op_b);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        m_hi = prod[63:32];
        m_lo = prod[31:0];
        chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        hilo_sel = 1'b0;
        #1;
        chk({tag, "_rd_lo"}, 64'(rd_data), 64'(m_lo));
        hilo_sel = 1'b1;
        #1;
        chk({tag, "_rd_hi"}, 64'(rd_data), 64'(m_hi));
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; flush = 1'b0;
        hilo_rd = 1'b0; hilo_sel = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wd = '0;
        m_hi = '0; m_lo = '0;

        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_mult("m2x4", 32'd2, 32'd4);
        run_mult("mffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mffff_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        chk("mffff_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
        run_mult("mzero", 32'd0, 32'd0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'd0;
            run_mult($sformatf("rand%0d", i), ra, rb);
        end

        // HI/LO read issued mid-multiply stalls until the result lands
        ra = $urandom;
        rb = $urandom;
        start_op(ra, rb);
        repeat (4) @(negedge clk);
        hilo_rd = 1'b1;
        hilo_sel = 1'b0;
        #1;
        n = 0;
        for (int g = 0; g < 100 && busy; g++) begin
            if (stall) n++;
            @(negedge clk);
        end
        {m_hi, m_lo} = {32'd0, ra} * {32'd0, rb};
        chk("rdstall_cycles", 64'(n), 64'd28);
        chk("rdstall_release", 64'(stall), 64'd0);
        chk("rdstall_rd_lo", 64'(rd_data), 64'(m_lo));
        hilo_sel = 1'b1;
        #1;
        chk("rdstall_rd_hi", 64'(rd_data), 64'(m_hi));
        hilo_rd = 1'b0;
        @(negedge clk);

        // MTHI/MTLO while idle
        we_hi = 1'b1; wd = 32'h1234;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b1; wd = 32'h5678;
        @(negedge clk);
        we_lo = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h5678;
        chk("mthi_idle", 64'(hi), 64'(m_hi));
        chk("mtlo_idle", 64'(lo), 64'(m_lo));

        // flush while idle suppresses start and writes
        start = 1'b1; flush = 1'b1; we_hi = 1'b1; wd = 32'hAAAA_5555; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; we_hi = 1'b0;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        chk("flush_idle_hi", 64'(hi), 64'(m_hi));

        // flush at RUN cycle 10 aborts with no done and HI/LO untouched
        start_op(32'hCAFE, 32'hBEEF);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_run_busy", 64'(busy), 64'd0);
        chk("flush_run_done", 64'(done), 64'd0);
        n = 0;
        for (int g = 0; g < 40; g++) begin
            if (done || busy) n++;
            @(negedge clk);
        end
        chk("flush_run_quiet", 64'(n), 64'd0);
        chk("flush_run_hi", 64'(hi), 64'(m_hi));
        chk("flush_run_lo", 64'(lo), 64'(m_lo));

        // start wins over a same-edge MTLO
        we_lo = 1'b1; wd = 32'h7777_7777;
        start_op(32'd6, 32'd7);
        we_lo = 1'b0;
        chk("start_prio_lo", 64'(lo), 64'(m_lo));
        chk("start_prio_busy", 64'(busy), 64'd1);
        for (int g = 0; g < 100 && busy; g++) @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd42;
        chk("start_prio_result", 64'(lo), 64'(m_lo));

        // MTHI DEADBEEF idle, then again while busy
        we_hi = 1'b1; wd = 32'hDEAD_BEEF;
        @(negedge clk);
        we_hi = 1'b0;
        m_hi = 32'hDEAD_BEEF;
        chk("mthi_deadbeef", 64'(hi), 64'(m_hi));
        start_op(32'd7, 32'd9);
        we_hi = 1'b1; wd = 32'h0BAD_F00D;
        #1;
        chk("mthi_busy_stall", 64'(stall), 64'd1);
        @(negedge clk);
        we_hi = 1'b0;
        chk("mthi_busy_hi", 64'(hi), 64'(m_hi));
        for (int g = 0; g < 100 && busy; g++) @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd63;
        chk("mthi_busy_res_hi", 64'(hi), 64'(m_hi));
        chk("mthi_busy_res_lo", 64'(lo), 64'(m_lo));

        // asynchronous reset mid-run, then restart immediately
        start_op(32'hFFFF_0000, 32'h1234_5678);
        repeat (10) @(negedge clk);
        hilo_rd = 1'b1; hilo_sel = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        chk("arst_rd", 64'(rd_data), 64'd0);
        hilo_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_mult("post_rst", 32'd3, 32'd5);
        chk("post_rst_lo15", 64'(lo), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
